// File: rtl/lc3_control_fsm.sv
// Microsequenced control unit for the LC-3 datapath: fetch, decode and execute one instruction
// at a time, driving every datapath select and load enable from the current state and ir.
module lc3_control_fsm (
    input  logic        i_Clk,
    input  logic        reset_,
    input  logic [15:0] ir,
    input  logic [2:0]  nzp,
    input  logic        R,
    output logic        SR2MUX_SEL,
    output logic        ADDR1MUX_SEL,
    output logic [1:0]  ADDR2MUX_SEL,
    output logic        MARMUX_SEL,
    output logic [1:0]  PCMUX_SEL,
    output logic        MIO_EN,
    output logic        RW,
    output logic [2:0]  DR,
    output logic [2:0]  SR1_SEL,
    output logic [2:0]  SR2_SEL,
    output logic        LD_REG,
    output logic        LD_CC,
    output logic        LD_IR,
    output logic        LD_PC,
    output logic        LD_MAR,
    output logic        LD_MDR,
    output logic        LD_BUS,
    output logic [1:0]  BUS_SEL,
    output logic [1:0]  ALUK,
    output logic        o_halt,
    output logic [4:0]  o_state
);

    typedef enum logic [4:0] {
        StF0, StF1, StF2, StF3, StF4, StDec,
        StA0, StA1, StBr, StJm0, StJm1, StJ0, StJ1, StJ2,
        StAd, StMa, StRd, StMb, StMa2, StRd2, StMb2, StWb,
        StS0, StS1, StWr, StT0, StT1, StT2, StT3, StHalt
    } state_e;

    localparam logic [3:0] OpBr   = 4'b0000;
    localparam logic [3:0] OpAdd  = 4'b0001;
    localparam logic [3:0] OpJsr  = 4'b0100;
    localparam logic [3:0] OpAnd  = 4'b0101;
    localparam logic [3:0] OpLdr  = 4'b0110;
    localparam logic [3:0] OpSt   = 4'b0011;
    localparam logic [3:0] OpStr  = 4'b0111;
    localparam logic [3:0] OpRti  = 4'b1000;
    localparam logic [3:0] OpNot  = 4'b1001;
    localparam logic [3:0] OpLdi  = 4'b1010;
    localparam logic [3:0] OpSti  = 4'b1011;
    localparam logic [3:0] OpJmp  = 4'b1100;
    localparam logic [3:0] OpRes  = 4'b1101;
    localparam logic [3:0] OpLea  = 4'b1110;
    localparam logic [3:0] OpTrap = 4'b1111;

    state_e     r_state;
    state_e     w_next;
    logic [3:0] w_op;

    assign w_op    = ir[15:12];
    assign o_state = r_state;

    always_ff @(posedge i_Clk or negedge reset_) begin
        if (!reset_) begin
            r_state <= StF0;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            StF0:   w_next = StF1;
            StF1:   w_next = StF2;
            StF2:   if (R) w_next = StF3;
            StF3:   w_next = StF4;
            StF4:   w_next = StDec;
            StDec: begin
                case (w_op)
                    OpAdd, OpAnd, OpNot: w_next = StA0;
                    OpBr:                w_next = StBr;
                    OpJmp:               w_next = StJm0;
                    OpJsr:               w_next = StJ0;
                    OpTrap:              w_next = StT0;
                    OpRti, OpRes:        w_next = StHalt;
                    default:             w_next = StAd;
                endcase
            end
            StA0:   w_next = StA1;
            StA1:   w_next = StF0;
            StBr:   w_next = StF0;
            StJm0:  w_next = StJm1;
            StJm1:  w_next = StF0;
            StJ0:   w_next = StJ1;
            StJ1:   w_next = ir[11] ? StF0 : StJ2;
            StJ2:   w_next = StF0;
            StAd:   w_next = (w_op == OpLea) ? StWb : StMa;
            StMa:   w_next = (w_op == OpSt || w_op == OpStr) ? StS0 : StRd;
            StRd:   if (R) w_next = StMb;
            StMb: begin
                if (w_op == OpLdi || w_op == OpSti) begin
                    w_next = StMa2;
                end else if (w_op == OpTrap) begin
                    w_next = StT3;
                end else begin
                    w_next = StWb;
                end
            end
            StMa2:  w_next = (w_op == OpLdi) ? StRd2 : StS0;
            StRd2:  if (R) w_next = StMb2;
            StMb2:  w_next = StWb;
            StWb:   w_next = StF0;
            StS0:   w_next = StS1;
            StS1:   w_next = StWr;
            StWr:   if (R) w_next = StF0;
            StT0:   w_next = StT1;
            StT1:   w_next = StT2;
            StT2:   w_next = StRd;
            StT3:   w_next = StF0;
            StHalt: w_next = StHalt;
            default: w_next = StF0;
        endcase
    end

    always_comb begin
        SR2MUX_SEL   = 1'b0;
        ADDR1MUX_SEL = 1'b0;
        ADDR2MUX_SEL = 2'd0;
        MARMUX_SEL   = 1'b0;
        PCMUX_SEL    = 2'd0;
        MIO_EN       = 1'b0;
        RW           = 1'b0;
        DR           = 3'd0;
        SR1_SEL      = 3'd0;
        SR2_SEL      = 3'd0;
        LD_REG       = 1'b0;
        LD_CC        = 1'b0;
        LD_IR        = 1'b0;
        LD_PC        = 1'b0;
        LD_MAR       = 1'b0;
        LD_MDR       = 1'b0;
        LD_BUS       = 1'b0;
        BUS_SEL      = 2'd0;
        ALUK         = 2'd0;
        o_halt       = 1'b0;
        unique case (r_state)
            StF0, StJ0, StT0: begin
                BUS_SEL = 2'd1;
                LD_BUS  = 1'b1;
            end
            StF1: begin
                LD_MAR    = 1'b1;
                PCMUX_SEL = 2'd2;
                LD_PC     = 1'b1;
            end
            // Memory read waits: MDR captures only on the cycle memory reports ready.
            StF2, StRd, StRd2: begin
                MIO_EN = 1'b1;
                LD_MDR = R;
            end
            StF3, StMb, StMb2: begin
                BUS_SEL = 2'd3;
                LD_BUS  = 1'b1;
            end
            StF4: LD_IR = 1'b1;
            StA0: begin
                SR1_SEL    = ir[8:6];
                SR2_SEL    = ir[2:0];
                SR2MUX_SEL = ~ir[5];
                ALUK       = (w_op == OpAnd) ? 2'd1 : (w_op == OpNot) ? 2'd2 : 2'd0;
                BUS_SEL    = 2'd2;
                LD_BUS     = 1'b1;
            end
            StA1: begin
                DR     = ir[11:9];
                LD_REG = 1'b1;
                LD_CC  = 1'b1;
            end
            StBr: begin
                if ((ir[11:9] & nzp) != 3'b000) begin
                    ADDR1MUX_SEL = 1'b1;
                    ADDR2MUX_SEL = 2'd1;
                    PCMUX_SEL    = 2'd1;
                    LD_PC        = 1'b1;
                end
            end
            StJm0: begin
                SR1_SEL = ir[8:6];
                ALUK    = 2'd3;
                BUS_SEL = 2'd2;
                LD_BUS  = 1'b1;
            end
            StJm1, StJ2, StT3: LD_PC = 1'b1;
            // R7 is written on the same edge the base register is captured onto the bus.
            StJ1: begin
                DR     = 3'd7;
                LD_REG = 1'b1;
                if (ir[11]) begin
                    ADDR1MUX_SEL = 1'b1;
                    PCMUX_SEL    = 2'd1;
                    LD_PC        = 1'b1;
                end else begin
                    SR1_SEL = ir[8:6];
                    ALUK    = 2'd3;
                    BUS_SEL = 2'd2;
                    LD_BUS  = 1'b1;
                end
            end
            StAd: begin
                if (w_op == OpLdr || w_op == OpStr) begin
                    SR1_SEL      = ir[8:6];
                    ADDR2MUX_SEL = 2'd2;
                end else begin
                    ADDR1MUX_SEL = 1'b1;
                    ADDR2MUX_SEL = 2'd1;
                end
                MARMUX_SEL = 1'b1;
                LD_BUS     = 1'b1;
            end
            StMa, StMa2, StT2: LD_MAR = 1'b1;
            StWb: begin
                DR     = ir[11:9];
                LD_REG = 1'b1;
                LD_CC  = (w_op != OpLea);
            end
            StS0: begin
                SR1_SEL = ir[11:9];
                ALUK    = 2'd3;
                BUS_SEL = 2'd2;
                LD_BUS  = 1'b1;
            end
            StS1: LD_MDR = 1'b1;
            StWr: begin
                MIO_EN = 1'b1;
                RW     = 1'b1;
            end
            StT1: begin
                DR     = 3'd7;
                LD_REG = 1'b1;
                LD_BUS = 1'b1;
            end
            StHalt: o_halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Bench for lc3_control_fsm: latency table, hand-written corner sequences, and random
// instructions checked cycle by cycle against a per-instruction micro-op list model.
module tb_lc3_control_fsm;

    typedef struct packed {
        logic       sr2mux;
        logic       addr1;
        logic [1:0] addr2;
        logic       marmux;
        logic [1:0] pcmux;
        logic       mio;
        logic       rw;
        logic [2:0] dr;
        logic [2:0] sr1;
        logic [2:0] sr2;
        logic       ld_reg;
        logic       ld_cc;
        logic       ld_ir;
        logic       ld_pc;
        logic       ld_mar;
        logic       ld_mdr;
        logic       ld_bus;
        logic [1:0] bus_sel;
        logic [1:0] aluk;
        logic       halt;
    } outs_t;

    typedef struct packed {
        outs_t o;
        logic  mem;
    } step_t;

    typedef struct {
        logic [15:0] ir;
        logic [2:0]  nzp;
        int          cycles;
    } vec_t;

    logic        i_Clk;
    logic        reset_;
    logic [15:0] ir;
    logic [2:0]  nzp;
    logic        R;
    logic        SR2MUX_SEL, ADDR1MUX_SEL, MARMUX_SEL, MIO_EN, RW;
    logic [1:0]  ADDR2MUX_SEL, PCMUX_SEL, BUS_SEL, ALUK;
    logic [2:0]  DR, SR1_SEL, SR2_SEL;
    logic        LD_REG, LD_CC, LD_IR, LD_PC, LD_MAR, LD_MDR, LD_BUS;
    logic        o_halt;
    logic [4:0]  o_state;

    outs_t act;
    int    n_checks;
    int    n_errors;
    int    cyc;
    step_t prog[$];
    vec_t  vecs[16];

    lc3_control_fsm u_dut (
        .i_Clk       (i_Clk),
        .reset_      (reset_),
        .ir          (ir),
        .nzp         (nzp),
        .R           (R),
        .SR2MUX_SEL  (SR2MUX_SEL),
        .ADDR1MUX_SEL(ADDR1MUX_SEL),
        .ADDR2MUX_SEL(ADDR2MUX_SEL),
        .MARMUX_SEL  (MARMUX_SEL),
        .PCMUX_SEL   (PCMUX_SEL),
        .MIO_EN      (MIO_EN),
        .RW          (RW),
        .DR          (DR),
        .SR1_SEL     (SR1_SEL),
        .SR2_SEL     (SR2_SEL),
        .LD_REG      (LD_REG),
        .LD_CC       (LD_CC),
        .LD_IR       (LD_IR),
        .LD_PC       (LD_PC),
        .LD_MAR      (LD_MAR),
        .LD_MDR      (LD_MDR),
        .LD_BUS      (LD_BUS),
        .BUS_SEL     (BUS_SEL),
        .ALUK        (ALUK),
        .o_halt      (o_halt),
        .o_state     (o_state)
    );

    always_comb begin
        act         = '0;
        act.sr2mux  = SR2MUX_SEL;
        act.addr1   = ADDR1MUX_SEL;
        act.addr2   = ADDR2MUX_SEL;
        act.marmux  = MARMUX_SEL;
        act.pcmux   = PCMUX_SEL;
        act.mio     = MIO_EN;
        act.rw      = RW;
        act.dr      = DR;
        act.sr1     = SR1_SEL;
        act.sr2     = SR2_SEL;
        act.ld_reg  = LD_REG;
        act.ld_cc   = LD_CC;
        act.ld_ir   = LD_IR;
        act.ld_pc   = LD_PC;
        act.ld_mar  = LD_MAR;
        act.ld_mdr  = LD_MDR;
        act.ld_bus  = LD_BUS;
        act.bus_sel = BUS_SEL;
        act.aluk    = ALUK;
        act.halt    = o_halt;
    end

    initial begin
        i_Clk = 1'b0;
        forever #5 i_Clk = ~i_Clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    // ---------------- expected-pattern helpers ----------------
    function automatic outs_t bus_src(input logic [1:0] sel);
        outs_t o = '0;
        o.bus_sel = sel;
        o.ld_bus  = 1'b1;
        return o;
    endfunction

    function automatic outs_t f1_pat();
        outs_t o = '0;
        o.ld_mar = 1'b1;
        o.pcmux  = 2'd2;
        o.ld_pc  = 1'b1;
        return o;
    endfunction

    function automatic outs_t rd_pat();
        outs_t o = '0;
        o.mio    = 1'b1;
        o.ld_mdr = 1'b1;
        return o;
    endfunction

    function automatic outs_t mar_pat();
        outs_t o = '0;
        o.ld_mar = 1'b1;
        return o;
    endfunction

    function automatic outs_t jump_pat();
        outs_t o = '0;
        o.ld_pc = 1'b1;
        return o;
    endfunction

    function automatic outs_t wr_pat();
        outs_t o = '0;
        o.mio = 1'b1;
        o.rw  = 1'b1;
        return o;
    endfunction

    function automatic outs_t pass_sr(input logic [2:0] r);
        outs_t o = bus_src(2'd2);
        o.sr1  = r;
        o.aluk = 2'd3;
        return o;
    endfunction

    function automatic outs_t wb_pat(input logic [15:0] i, input logic cc);
        outs_t o = '0;
        o.dr     = i[11:9];
        o.ld_reg = 1'b1;
        o.ld_cc  = cc;
        return o;
    endfunction

    function automatic outs_t ad_pat(input logic [15:0] i);
        outs_t o = bus_src(2'd0);
        o.marmux = 1'b1;
        if (i[15:12] == 4'h6 || i[15:12] == 4'h7) begin
            o.sr1   = i[8:6];
            o.addr2 = 2'd2;
        end else begin
            o.addr1 = 1'b1;
            o.addr2 = 2'd1;
        end
        return o;
    endfunction

    // ---------------- checking / timing helpers ----------------
    task automatic check(input outs_t exp, input string name);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (cycle %0d): got %h, want %h", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input int got, input int want, input string name);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic next_cycle();
        @(negedge i_Clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        R      = 1'b1;
        reset_ = 1'b0;
        @(negedge i_Clk);
        #1;
        reset_ = 1'b1;
        cyc    = 0;
    endtask

    task automatic adv_to(input int k);
        while (cyc < k) begin
            R = 1'b1;
            next_cycle();
        end
    endtask

    task automatic probe(input outs_t e, input string name);
        #1;
        check(e, name);
    endtask

    // ---------------- reference model: micro-op list per instruction ----------------
    task automatic push(input outs_t o, input logic mem = 1'b0);
        step_t s;
        s.o   = o;
        s.mem = mem;
        prog.push_back(s);
    endtask

    task automatic build(input logic [15:0] i, input logic [2:0] cc);
        logic [3:0] op;
        outs_t      o;
        logic       is_load;
        op = i[15:12];
        prog.delete();
        push(bus_src(2'd1));
        push(f1_pat());
        push(rd_pat(), 1'b1);
        push(bus_src(2'd3));
        o = '0;
        o.ld_ir = 1'b1;
        push(o);
        push('0);
        case (op)
            4'h1, 4'h5, 4'h9: begin
                o        = bus_src(2'd2);
                o.sr1    = i[8:6];
                o.sr2    = i[2:0];
                o.sr2mux = ~i[5];
                o.aluk   = (op == 4'h1) ? 2'd0 : (op == 4'h5) ? 2'd1 : 2'd2;
                push(o);
                push(wb_pat(i, 1'b1));
            end
            4'h0: begin
                o = '0;
                if ((i[11:9] & cc) != 3'b000) begin
                    o.addr1 = 1'b1;
                    o.addr2 = 2'd1;
                    o.pcmux = 2'd1;
                    o.ld_pc = 1'b1;
                end
                push(o);
            end
            4'hC: begin
                push(pass_sr(i[8:6]));
                push(jump_pat());
            end
            4'h4: begin
                push(bus_src(2'd1));
                if (i[11]) begin
                    o       = '0;
                    o.addr1 = 1'b1;
                    o.pcmux = 2'd1;
                    o.ld_pc = 1'b1;
                end else begin
                    o = pass_sr(i[8:6]);
                end
                o.dr     = 3'd7;
                o.ld_reg = 1'b1;
                push(o);
                if (!i[11]) push(jump_pat());
            end
            4'hE: begin
                push(ad_pat(i));
                push(wb_pat(i, 1'b0));
            end
            4'hF: begin
                push(bus_src(2'd1));
                o        = bus_src(2'd0);
                o.dr     = 3'd7;
                o.ld_reg = 1'b1;
                push(o);
                push(mar_pat());
                push(rd_pat(), 1'b1);
                push(bus_src(2'd3));
                push(jump_pat());
            end
            default: begin
                is_load = (op == 4'h2 || op == 4'h6 || op == 4'hA);
                push(ad_pat(i));
                push(mar_pat());
                if (is_load || op == 4'hB) begin
                    push(rd_pat(), 1'b1);
                    push(bus_src(2'd3));
                end
                if (op == 4'hA || op == 4'hB) push(mar_pat());
                if (op == 4'hA) begin
                    push(rd_pat(), 1'b1);
                    push(bus_src(2'd3));
                end
                if (is_load) begin
                    push(wb_pat(i, 1'b1));
                end else begin
                    push(pass_sr(i[11:9]));
                    o        = '0;
                    o.ld_mdr = 1'b1;
                    push(o);
                    push(wr_pat(), 1'b1);
                end
            end
        endcase
    endtask

    // Memory steps are held for 0..3 random not-ready cycles; outside them R is noise.
    task automatic run_prog();
        int    cnt;
        int    zz;
        outs_t e;
        logic  r;
        foreach (prog[k]) begin
            cnt = 0;
            zz  = int'($urandom_range(0, 3));
            forever begin
                if (prog[k].mem) r = (cnt >= zz);
                else r = 1'($urandom);
                R = r;
                #1;
                e = prog[k].o;
                if (prog[k].mem) e.ld_mdr = prog[k].o.ld_mdr & r;
                check(e, $sformatf("model ir=%h step %0d", ir, k));
                next_cycle();
                if (!prog[k].mem || r) break;
                cnt++;
            end
        end
    endtask

    // Runs one instruction from reset, holding R low for `zeros` cycles of every memory wait.
    task automatic lat_check(input logic [15:0] i, input logic [2:0] cc, input int zeros,
                             input int n, output int n_mdr, output int n_mar);
        int    cnt;
        string nm;
        do_reset();
        ir    = i;
        nzp   = cc;
        cnt   = 0;
        n_mdr = 0;
        n_mar = 0;
        nm    = $sformatf("latency ir=%h", i);
        for (int c = 0; c <= n + 1; c++) begin
            if (act.mio) begin
                R = (cnt >= zeros);
                cnt++;
            end else begin
                R   = 1'b1;
                cnt = 0;
            end
            #1;
            if (c < n && act.ld_mdr) n_mdr++;
            if (c >= 6 && c < n && act.ld_mar) n_mar++;
            if (c == n) check(bus_src(2'd1), {nm, " F0"});
            if (c == n + 1) check(f1_pat(), {nm, " F1"});
            next_cycle();
        end
    endtask

    initial begin
        outs_t       e;
        int          n_mdr;
        int          n_mar;
        logic [15:0] rir;

        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        ir       = 16'h0000;
        nzp      = 3'b000;
        R        = 1'b1;
        reset_   = 1'b0;

        vecs[0]  = '{16'h1042, 3'b000, 8};
        vecs[1]  = '{16'h5020, 3'b000, 8};
        vecs[2]  = '{16'h903F, 3'b000, 8};
        vecs[3]  = '{16'h0A05, 3'b010, 7};
        vecs[4]  = '{16'h0A05, 3'b100, 7};
        vecs[5]  = '{16'hC1C0, 3'b000, 8};
        vecs[6]  = '{16'h4800, 3'b000, 8};
        vecs[7]  = '{16'h41C0, 3'b000, 9};
        vecs[8]  = '{16'h2201, 3'b000, 11};
        vecs[9]  = '{16'h6241, 3'b000, 11};
        vecs[10] = '{16'hA203, 3'b000, 14};
        vecs[11] = '{16'h3201, 3'b000, 11};
        vecs[12] = '{16'h7A81, 3'b000, 11};
        vecs[13] = '{16'hB201, 3'b000, 14};
        vecs[14] = '{16'hF025, 3'b000, 12};
        vecs[15] = '{16'hE201, 3'b000, 8};

        foreach (vecs[v]) lat_check(vecs[v].ir, vecs[v].nzp, 0, vecs[v].cycles, n_mdr, n_mar);

        // LDI with every wait lasting three cycles: 14 + 3*2 cycles.
        lat_check(16'hA203, 3'b000, 2, 20, n_mdr, n_mar);
        check_int(n_mdr, 3, "LDI memory reads");
        check_int(n_mar, 2, "LDI LD_MAR pulses");

        // ADD R0,R1,R2
        do_reset();
        ir  = 16'h1042;
        nzp = 3'b000;
        probe(bus_src(2'd1), "reset F0");
        adv_to(6);
        e        = bus_src(2'd2);
        e.sr1    = 3'd1;
        e.sr2    = 3'd2;
        e.sr2mux = 1'b1;
        probe(e, "ADD A0");
        adv_to(7);
        e        = '0;
        e.ld_reg = 1'b1;
        e.ld_cc  = 1'b1;
        probe(e, "ADD A1");

        // BRnp not taken, then taken
        do_reset();
        ir  = 16'h0A05;
        nzp = 3'b010;
        adv_to(6);
        probe('0, "BR not taken");
        do_reset();
        nzp = 3'b100;
        adv_to(6);
        e       = '0;
        e.addr1 = 1'b1;
        e.addr2 = 2'd1;
        e.pcmux = 2'd1;
        e.ld_pc = 1'b1;
        probe(e, "BR taken");

        // STR R5,R2,#1 with a held write
        do_reset();
        ir  = 16'h7A81;
        nzp = 3'b000;
        adv_to(6);
        e        = bus_src(2'd0);
        e.marmux = 1'b1;
        e.sr1    = 3'd2;
        e.addr2  = 2'd2;
        probe(e, "STR AD");
        adv_to(8);
        probe(pass_sr(3'd5), "STR S0");
        adv_to(10);
        for (int k = 0; k < 4; k++) begin
            R = 1'b0;
            probe(wr_pat(), "STR WR hold");
            next_cycle();
        end
        R = 1'b1;
        probe(wr_pat(), "STR WR ready");
        next_cycle();
        probe(bus_src(2'd1), "STR back to F0");

        // Asynchronous reset in the middle of a write wait
        do_reset();
        ir = 16'h7A81;
        adv_to(10);
        R = 1'b0;
        probe(wr_pat(), "WR before reset");
        reset_ = 1'b0;
        #1;
        check(bus_src(2'd1), "async reset in WR");
        reset_ = 1'b1;
        cyc    = 0;
        R      = 1'b1;
        next_cycle();
        probe(f1_pat(), "F1 after reset");

        // TRAP x25
        do_reset();
        ir = 16'hF025;
        adv_to(7);
        e        = bus_src(2'd0);
        e.dr     = 3'd7;
        e.ld_reg = 1'b1;
        probe(e, "TRAP T1");
        adv_to(11);
        probe(jump_pat(), "TRAP T3");

        // Reserved opcode halts and stays halted
        do_reset();
        ir = 16'hD000;
        adv_to(6);
        e      = '0;
        e.halt = 1'b1;
        for (int k = 0; k < 10; k++) begin
            R = 1'($urandom);
            probe(e, "HALT reserved");
            next_cycle();
        end
        do_reset();
        ir = 16'h8000;
        adv_to(6);
        probe(e, "HALT RTI");

        // Random instruction stream, back to back
        do_reset();
        for (int n = 0; n < 300; n++) begin
            rir = 16'($urandom);
            while (rir[15:12] == 4'h8 || rir[15:12] == 4'hD) rir = 16'($urandom);
            ir  = rir;
            nzp = 3'($urandom);
            build(rir, nzp);
            run_prog();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
